// File: rtl/player_move_pkg.sv
// Shared types and default constants for the player movement controller.
package player_move_pkg;

  typedef enum logic [1:0] {IDLE, SLOW, FAST} move_state_t;

  localparam int DEF_W           = 10;
  localparam int DEF_X_MAX       = 639;
  localparam int DEF_Y_MAX       = 479;
  localparam int DEF_X_INIT      = 320;
  localparam int DEF_Y_INIT      = 240;
  localparam int DEF_STEP        = 1;
  localparam int DEF_STEP_FAST   = 4;
  localparam int DEF_DB_TICKS    = 4;
  localparam int DEF_ACCEL_TICKS = 8;

endpackage

// File: rtl/player_move_if.sv
// Button inputs and position outputs of the movement controller.
interface player_move_if #(parameter int W = 10);
  logic         btnClk;
  logic         btnU, btnD, btnL, btnR;
  logic [W-1:0] posX, posY;
  logic         moving;
  logic         tick;

  modport master (output btnClk, btnU, btnD, btnL, btnR,
                  input  posX, posY, moving, tick);
  modport slave  (input  btnClk, btnU, btnD, btnL, btnR,
                  output posX, posY, moving, tick);
endinterface

// File: rtl/btn_debounce.sv
// 2-flop synchronizer followed by a tick-qualified counting debouncer.
module btn_debounce #(
  parameter int DB_TICKS = 4
) (
  input  logic Clk_In,
  input  logic rst,
  input  logic tk,
  input  logic raw,
  output logic db
);
  localparam int CW = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0] L_DB = CW'(DB_TICKS);

  logic [1:0]    r_sync;
  logic          r_cand;
  logic [CW-1:0] r_cnt;
  logic          r_db;
  logic [CW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CW'(1);
  assign db        = r_db;

  always_ff @(posedge Clk_In) begin
    if (rst) begin
      r_sync <= '0;
      r_cand <= 1'b0;
      r_cnt  <= L_DB;
      r_db   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      if (tk) begin
        // A changed sample restarts the run; a full run commits the level.
        if (r_sync[1] != r_cand) begin
          r_cand <= r_sync[1];
          r_cnt  <= CW'(1);
        end else if (r_cnt < L_DB) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == L_DB) r_db <= r_cand;
        end
      end
    end
  end
endmodule

// File: rtl/player_move_ctrl.sv
// Steps the player position once per btnClk rising edge from debounced
// direction buttons, with edge saturation and hold-to-accelerate.
module player_move_ctrl
  import player_move_pkg::*;
#(
  parameter int W           = DEF_W,
  parameter int X_MAX       = DEF_X_MAX,
  parameter int Y_MAX       = DEF_Y_MAX,
  parameter int X_INIT      = DEF_X_INIT,
  parameter int Y_INIT      = DEF_Y_INIT,
  parameter int STEP        = DEF_STEP,
  parameter int STEP_FAST   = DEF_STEP_FAST,
  parameter int DB_TICKS    = DEF_DB_TICKS,
  parameter int ACCEL_TICKS = DEF_ACCEL_TICKS
) (
  input  logic           Clk_In,
  input  logic           rst,
  player_move_if.slave   bus
);
  localparam int AW = $clog2(ACCEL_TICKS + 1);
  localparam logic [W:0]    L_XMAX  = (W+1)'(X_MAX);
  localparam logic [W:0]    L_YMAX  = (W+1)'(Y_MAX);
  localparam logic [W:0]    L_STEP  = (W+1)'(STEP);
  localparam logic [W:0]    L_FAST  = (W+1)'(STEP_FAST);
  localparam logic [AW-1:0] L_ACCEL = AW'(ACCEL_TICKS);

  logic          r_bq, r_bqq, w_tk;
  logic [3:0]    w_raw, w_db;
  logic          w_right, w_left, w_down, w_up, w_active;
  move_state_t   r_state, w_state_nxt;
  logic [AW-1:0] r_acc, w_acc_nxt, w_acc_inc;
  logic [W-1:0]  r_x, r_y, w_x_nxt, w_y_nxt;
  logic [W:0]    w_step;
  logic          r_moving, r_tick;

  // Reset to 1 so a btnClk already high at reset release gives no tick.
  always_ff @(posedge Clk_In) begin
    if (rst) begin
      r_bq  <= 1'b1;
      r_bqq <= 1'b1;
    end else begin
      r_bq  <= bus.btnClk;
      r_bqq <= r_bq;
    end
  end
  assign w_tk = r_bq & ~r_bqq;

  // Bit order {U, D, L, R}.
  assign w_raw = {bus.btnU, bus.btnD, bus.btnL, bus.btnR};
  btn_debounce #(.DB_TICKS(DB_TICKS)) u_db [3:0] (
    .Clk_In (Clk_In),
    .rst    (rst),
    .tk     (w_tk),
    .raw    (w_raw),
    .db     (w_db)
  );

  assign w_right  = w_db[0] & ~w_db[1];
  assign w_left   = w_db[1] & ~w_db[0];
  assign w_down   = w_db[2] & ~w_db[3];
  assign w_up     = w_db[3] & ~w_db[2];
  assign w_active = w_right | w_left | w_down | w_up;
  assign w_acc_inc = r_acc + AW'(1);

  // One saturating axis step, computed one bit wider to catch overflow.
  function automatic logic [W-1:0] step_axis(input logic [W-1:0] p,
      input logic inc, input logic dec, input logic [W:0] s,
      input logic [W:0] lim);
    logic [W:0] t;
    t = {1'b0, p};
    if (inc) begin
      t = t + s;
      if (t > lim) t = lim;
    end else if (dec) begin
      t = (t < s) ? '0 : t - s;
    end
    return t[W-1:0];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_step      = L_STEP;
    if (w_tk) begin
      if (!w_active) begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
      end else begin
        case (r_state)
          IDLE: begin
            w_acc_nxt   = AW'(1);
            w_state_nxt = (ACCEL_TICKS == 1) ? FAST : SLOW;
          end
          SLOW: begin
            w_acc_nxt = w_acc_inc;
            if (w_acc_inc == L_ACCEL) w_state_nxt = FAST;
          end
          FAST:    w_step = L_FAST;
          default: w_state_nxt = IDLE;
        endcase
        w_x_nxt = step_axis(r_x, w_right, w_left, w_step, L_XMAX);
        w_y_nxt = step_axis(r_y, w_down,  w_up,   w_step, L_YMAX);
      end
    end
  end

  always_ff @(posedge Clk_In) begin
    if (rst) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_x      <= W'(X_INIT);
      r_y      <= W'(Y_INIT);
      r_moving <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_x      <= w_x_nxt;
      r_y      <= w_y_nxt;
      r_moving <= (w_state_nxt != IDLE);
      r_tick   <= w_tk;
    end
  end

  assign bus.posX   = r_x;
  assign bus.posY   = r_y;
  assign bus.moving = r_moving;
  assign bus.tick   = r_tick;
endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed bench for player_move_ctrl; btnClk period is scaled down to
// 20 Clk_In cycles so the long hold scenarios stay short.
module tb_player_move_ctrl;
  localparam int P    = 20;
  localparam int HALF = P / 2;

  logic clk = 1'b0;
  logic rst;
  logic div_hold;
  int   dcnt;
  int   vecs = 0;
  int   errs = 0;

  player_move_if #(.W(10)) bus ();

  player_move_ctrl dut (
    .Clk_In (clk),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Divider model: counter on Clk_In, high for the first half-period.
  always @(posedge clk) begin
    if (div_hold) dcnt <= 0;
    else          dcnt <= (dcnt == P - 1) ? 0 : dcnt + 1;
  end
  assign bus.btnClk = div_hold ? 1'b1 : (dcnt < HALF);

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick && n < 4 * P);
    chk("tick_seen", int'(bus.tick), 1);
  endtask

  task automatic pulse_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic release_all();
    bus.btnU = 0; bus.btnD = 0; bus.btnL = 0; bus.btnR = 0;
    repeat (6) wait_tick();
  endtask

  initial begin
    logic quiet, bad;
    rst = 1'b1; div_hold = 1'b1;
    bus.btnU = 0; bus.btnD = 0; bus.btnL = 0; bus.btnR = 0;
    repeat (5) @(negedge clk);
    chk("rst_posX", int'(bus.posX), 320);
    chk("rst_posY", int'(bus.posY), 240);
    chk("rst_moving", int'(bus.moving), 0);
    chk("rst_tick", int'(bus.tick), 0);
    rst = 1'b0; div_hold = 1'b0;

    // btnClk high through reset release must not tick
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.tick) quiet = 1'b0;
    end
    chk("no_tick_while_high", int'(quiet), 1);
    wait_tick();
    chk("first_tick_posX", int'(bus.posX), 320);
    @(negedge clk);
    chk("tick_width", int'(bus.tick), 0);

    // Hold right
    bus.btnR = 1;
    for (int i = 1; i <= 4; i++) begin
      wait_tick();
      chk("hold_r_wait_posX", int'(bus.posX), 320);
      chk("hold_r_wait_moving", int'(bus.moving), 0);
    end
    wait_tick();
    chk("hold_r_t5_posX", int'(bus.posX), 321);
    chk("hold_r_t5_moving", int'(bus.moving), 1);
    repeat (7) wait_tick();
    chk("hold_r_t12_posX", int'(bus.posX), 328);
    wait_tick();
    chk("hold_r_t13_fast", int'(bus.posX), 332);
    bus.btnR = 0;
    for (int i = 1; i <= 4; i++) begin
      wait_tick();
      chk("rel_moving", int'(bus.moving), 1);
      chk("rel_posX", int'(bus.posX), 332 + 4 * i);
    end
    wait_tick();
    chk("rel_idle_moving", int'(bus.moving), 0);
    chk("rel_idle_posX", int'(bus.posX), 348);

    // Bounce on L
    pulse_rst();
    chk("bounce_rst_posX", int'(bus.posX), 320);
    for (int i = 0; i < 12; i++) begin
      bus.btnL = ((i / 2) % 2 == 0);
      wait_tick();
      chk("bounce_posX", int'(bus.posX), 320);
      chk("bounce_moving", int'(bus.moving), 0);
    end
    release_all();

    // Saturation right then up
    bus.btnR = 1; bad = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      wait_tick();
      if (bus.posX > 10'd639) bad = 1'b1;
      if (i == 150 || i == 200) chk("sat_right_posX", int'(bus.posX), 639);
    end
    chk("sat_right_over", int'(bad), 0);
    release_all();
    chk("sat_right_hold", int'(bus.posX), 639);
    bus.btnU = 1; bad = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      wait_tick();
      if (bus.posY > 10'd240) bad = 1'b1;
      if (i == 150 || i == 200) chk("sat_up_posY", int'(bus.posY), 0);
    end
    chk("sat_up_wrap", int'(bad), 0);
    release_all();
    chk("sat_up_hold", int'(bus.posY), 0);

    // Opposing buttons
    pulse_rst();
    bus.btnU = 1; bus.btnD = 1;
    repeat (8) wait_tick();
    chk("ud_posY", int'(bus.posY), 240);
    chk("ud_moving", int'(bus.moving), 0);
    bus.btnR = 1;
    repeat (4) wait_tick();
    chk("udr_wait_posX", int'(bus.posX), 320);
    wait_tick();
    chk("udr_posX", int'(bus.posX), 321);
    chk("udr_posY", int'(bus.posY), 240);
    wait_tick();
    chk("udr_posX2", int'(bus.posX), 322);
    bus.btnL = 1;
    repeat (4) wait_tick();
    chk("lr_drain_posX", int'(bus.posX), 326);
    wait_tick();
    chk("lr_posX", int'(bus.posX), 326);
    chk("lr_moving", int'(bus.moving), 0);
    repeat (3) wait_tick();
    chk("lr_hold_posX", int'(bus.posX), 326);
    chk("lr_hold_posY", int'(bus.posY), 240);
    release_all();

    // Reset mid-motion
    pulse_rst();
    bus.btnR = 1;
    repeat (13) wait_tick();
    chk("mid_fast_posX", int'(bus.posX), 332);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_posX", int'(bus.posX), 320);
    chk("mid_rst_moving", int'(bus.moving), 0);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_tick();
      chk("mid_wait_posX", int'(bus.posX), 320);
    end
    wait_tick();
    chk("mid_t5_posX", int'(bus.posX), 321);
    chk("mid_t5_moving", int'(bus.moving), 1);
    bus.btnR = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
